// File: rtl/ula_decoder_pkg.sv
// Shared opcode and ULA operation-code constants plus the decoded bundle type.
// Used by the decoder, the ULA and the control unit.
package ula_decoder_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] ULA_ADD = 3'b000;
   localparam logic [2:0] ULA_SUB = 3'b001;
   localparam logic [2:0] ULA_AND = 3'b010;
   localparam logic [2:0] ULA_OR  = 3'b011;
   localparam logic [2:0] ULA_XOR = 3'b100;
   localparam logic [2:0] ULA_SLT = 3'b101;
   localparam logic [2:0] ULA_SLL = 3'b110;
   localparam logic [2:0] ULA_SRL = 3'b111;

   typedef struct packed {
      logic [2:0] ula_control;
      logic       src_b_imm;
      logic       reg_write;
      logic       is_branch;
      logic       branch_on_z;
      logic       illegal;
   } bundle_t;

   // Arithmetic funct3 map shared by R-type and I-ALU; returns {illegal, ula_code}.
   function automatic logic [3:0] alu_map(input logic [2:0] funct3,
                                          input logic       sub_sel,
                                          input logic       arith_shift);
      logic [3:0] res;
      case (funct3)
         3'b000:  res = {1'b0, (sub_sel ? ULA_SUB : ULA_ADD)};
         3'b001:  res = {1'b0, ULA_SLL};
         3'b010:  res = {1'b0, ULA_SLT};
         3'b100:  res = {1'b0, ULA_XOR};
         3'b101:  res = arith_shift ? {1'b1, ULA_ADD} : {1'b0, ULA_SRL};
         3'b110:  res = {1'b0, ULA_OR};
         3'b111:  res = {1'b0, ULA_AND};
         default: res = {1'b1, ULA_ADD};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ula_decoder_decode_comb.sv
// Purely combinational RV32I field-to-bundle decode for the ULA.
// Branch decode is enabled by defining ULA_DECODER_BRANCH_EN.
module ula_decode_comb
   import ula_decoder_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] ula_control,
   output logic       src_b_imm,
   output logic       reg_write,
   output logic       is_branch,
   output logic       branch_on_z,
   output logic       illegal
);

   logic [3:0] r_map;
   logic [3:0] i_map;

   assign r_map = alu_map(funct3, funct7b5, funct7b5);
   assign i_map = alu_map(funct3, 1'b0, funct7b5);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      ula_control = ULA_ADD;
      src_b_imm   = 1'b0;
      reg_write   = 1'b0;
      is_branch   = 1'b0;
      branch_on_z = 1'b0;
      illegal     = 1'b0;
      case (op)
         OP_R: begin
            {illegal, ula_control} = r_map;
            reg_write              = 1'b1;
         end
         OP_I: begin
            {illegal, ula_control} = i_map;
            src_b_imm              = 1'b1;
            reg_write              = 1'b1;
         end
         OP_LOAD: begin
            src_b_imm = 1'b1;
            reg_write = 1'b1;
         end
         OP_STORE: begin
            src_b_imm = 1'b1;
         end
`ifdef ULA_DECODER_BRANCH_EN
         OP_BRANCH: begin
            ula_control = ULA_SUB;
            is_branch   = 1'b1;
            case (funct3)
               3'b000:  branch_on_z = 1'b1;
               3'b001:  branch_on_z = 1'b0;
               default: illegal     = 1'b1;
            endcase
         end
`endif
         default: illegal = 1'b1;
      endcase
      // An illegal bundle must not steer the datapath.
      if (illegal) begin
         ula_control = ULA_ADD;
         src_b_imm   = 1'b0;
         reg_write   = 1'b0;
         is_branch   = 1'b0;
         branch_on_z = 1'b0;
      end
   end

endmodule

// File: rtl/ula_decoder.sv
// Registered ULA decoder with skid buffer and saturating illegal counter.
// Optional macro ULA_DECODER_BRANCH_EN enables BEQ/BNE decode.
module ula_decoder
   import ula_decoder_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       ula_control,
   output logic             src_b_imm,
   output logic             reg_write,
   output logic             is_branch,
   output logic             branch_on_z,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   bundle_t dec;
   bundle_t out_q, out_d;
   bundle_t skid_q, skid_d;
   logic    out_valid_q, out_valid_d;
   logic    skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic    accept, drain;

   ula_decode_comb u_decode (
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .ula_control (dec.ula_control),
      .src_b_imm   (dec.src_b_imm),
      .reg_write   (dec.reg_write),
      .is_branch   (dec.is_branch),
      .branch_on_z (dec.branch_on_z),
      .illegal     (dec.illegal)
   );

   assign in_ready = ~skid_valid_q;
   assign accept   = in_valid & in_ready;
   assign drain    = out_valid_q & out_ready;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;
      if (skid_valid_q) begin
         // in_ready is low, so only the held skid bundle can move forward.
         if (drain) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (!out_valid_q || drain) begin
         out_valid_d = accept;
         if (accept) out_d = dec;
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
      if (drain && out_q.illegal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   // NOTE: data registers are reset too, so bundle outputs read 0 after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from pre-edge values.
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign ula_control = out_q.ula_control;
   assign src_b_imm   = out_q.src_b_imm;
   assign reg_write   = out_q.reg_write;
   assign is_branch   = out_q.is_branch;
   assign branch_on_z = out_q.branch_on_z;
   assign illegal     = out_q.illegal;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ula_decoder.sv
// Directed self-checking bench for ula_decoder (counter width 2 to reach saturation).
// Branch expectations follow ULA_DECODER_BRANCH_EN.
module tb_ula_decoder;

   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [6:0]    op;
   logic [2:0]    funct3;
   logic          funct7b5;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    ula_control;
   logic          src_b_imm;
   logic          reg_write;
   logic          is_branch;
   logic          branch_on_z;
   logic          illegal;
   logic [CW-1:0] illegal_cnt;

   int total = 0;
   int bad   = 0;

   ula_decoder #(.CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ula_control (ula_control),
      .src_b_imm   (src_b_imm),
      .reg_write   (reg_write),
      .is_branch   (is_branch),
      .branch_on_z (branch_on_z),
      .illegal     (illegal),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3, input logic b5);
      in_valid = v;
      op       = o;
      funct3   = f3;
      funct7b5 = b5;
   endtask

   // {out_valid, ula_control, src_b_imm, reg_write, is_branch, branch_on_z, illegal}
   function automatic logic [31:0] obs_vec();
      return {23'd0, out_valid, ula_control, src_b_imm, reg_write, is_branch, branch_on_z, illegal};
   endfunction

   function automatic logic [31:0] exp_vec(input logic [2:0] u, input logic imm, input logic rw,
                                           input logic br, input logic boz, input logic ill);
      return {23'd0, 1'b1, u, imm, rw, br, boz, ill};
   endfunction

   localparam logic [6:0] R  = 7'b0110011;
   localparam logic [6:0] I  = 7'b0010011;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;
   localparam logic [6:0] BR = 7'b1100011;

   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 7'd0, 3'd0, 1'b0);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_cnt", illegal_cnt, 0);
      check("rst_bundle", obs_vec(), 0);

      // Fill output and skid registers, then reset mid-transfer.
      drive(1'b1, R, 3'b011, 1'b0);
      tick();
      drive(1'b1, R, 3'b000, 1'b0);
      tick();
      check("skid_full_in_ready", in_ready, 1'b0);
      reset = 1'b1;
      #1;
      check("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_in_ready", in_ready, 1'b1);
      check("async_rst_bundle", obs_vec(), 0);
      drive(1'b0, 7'd0, 3'd0, 1'b0);
      tick();
      reset = 1'b0;

      // Decode sweep, one bundle per cycle.
      out_ready = 1'b1;
      drive(1'b1, R, 3'b000, 1'b1);
      tick();
      check("r_sub", obs_vec(), exp_vec(3'b001, 0, 1, 0, 0, 0));
      drive(1'b1, I, 3'b000, 1'b1);
      tick();
      check("i_add_b5", obs_vec(), exp_vec(3'b000, 1, 1, 0, 0, 0));
      drive(1'b1, ST, 3'b010, 1'b0);
      tick();
      check("store", obs_vec(), exp_vec(3'b000, 1, 0, 0, 0, 0));
      drive(1'b1, LD, 3'b010, 1'b0);
      tick();
      check("load", obs_vec(), exp_vec(3'b000, 1, 1, 0, 0, 0));
      drive(1'b1, R, 3'b101, 1'b0);
      tick();
      check("r_srl", obs_vec(), exp_vec(3'b111, 0, 1, 0, 0, 0));
      drive(1'b1, I, 3'b010, 1'b0);
      tick();
      check("i_slt", obs_vec(), exp_vec(3'b101, 1, 1, 0, 0, 0));
      drive(1'b1, I, 3'b001, 1'b0);
      tick();
      check("i_sll", obs_vec(), exp_vec(3'b110, 1, 1, 0, 0, 0));
      drive(1'b1, R, 3'b100, 1'b0);
      tick();
      check("r_xor", obs_vec(), exp_vec(3'b100, 0, 1, 0, 0, 0));
      drive(1'b1, R, 3'b110, 1'b0);
      tick();
      check("r_or", obs_vec(), exp_vec(3'b011, 0, 1, 0, 0, 0));
      drive(1'b1, R, 3'b111, 1'b0);
      tick();
      check("r_and", obs_vec(), exp_vec(3'b010, 0, 1, 0, 0, 0));
      check("cnt_legal", illegal_cnt, 0);

      // Illegal encodings; the count moves when each bundle is transferred.
      drive(1'b1, R, 3'b011, 1'b0);
      tick();
      check("sltu", obs_vec(), exp_vec(3'b000, 0, 0, 0, 0, 1));
      drive(1'b1, I, 3'b101, 1'b1);
      tick();
      check("srai", obs_vec(), exp_vec(3'b000, 0, 0, 0, 0, 1));
      check("cnt_1", illegal_cnt, 1);
      drive(1'b1, 7'b0110111, 3'b000, 1'b0);
      tick();
      check("lui", obs_vec(), exp_vec(3'b000, 0, 0, 0, 0, 1));
      check("cnt_2", illegal_cnt, 2);
      drive(1'b1, I, 3'b011, 1'b0);
      tick();
      check("i_sltu", obs_vec(), exp_vec(3'b000, 0, 0, 0, 0, 1));
      check("cnt_3", illegal_cnt, 3);
      drive(1'b1, 7'b1111111, 3'b111, 1'b1);
      tick();
      check("cnt_sat_4", illegal_cnt, 3);
      drive(1'b0, 7'd0, 3'd0, 1'b0);
      tick();
      check("cnt_sat_5", illegal_cnt, 3);
      check("drained_valid", out_valid, 1'b0);

      // BNE decode depends on the branch feature.
      drive(1'b1, BR, 3'b001, 1'b0);
      tick();
`ifdef ULA_DECODER_BRANCH_EN
      check("bne", obs_vec(), exp_vec(3'b001, 0, 0, 1, 0, 0));
`else
      check("bne_off", obs_vec(), exp_vec(3'b000, 0, 0, 0, 0, 1));
`endif
      drive(1'b0, 7'd0, 3'd0, 1'b0);
      tick();
      check("cnt_after_br", illegal_cnt, 3);

      // Backpressure: A held, B in skid, C stalled, then ordered drain.
      out_ready = 1'b0;
      drive(1'b1, R, 3'b000, 1'b0);
      tick();
      check("bp_a", obs_vec(), exp_vec(3'b000, 0, 1, 0, 0, 0));
      drive(1'b1, R, 3'b100, 1'b0);
      tick();
      check("bp_a_hold1", obs_vec(), exp_vec(3'b000, 0, 1, 0, 0, 0));
      check("bp_in_ready_lo", in_ready, 1'b0);
      drive(1'b1, I, 3'b110, 1'b0);
      tick();
      check("bp_a_hold2", obs_vec(), exp_vec(3'b000, 0, 1, 0, 0, 0));
      check("bp_c_stalled", in_ready, 1'b0);
      out_ready = 1'b1;
      tick();
      check("bp_b", obs_vec(), exp_vec(3'b100, 0, 1, 0, 0, 0));
      check("bp_in_ready_hi", in_ready, 1'b1);
      tick();
      check("bp_c", obs_vec(), exp_vec(3'b011, 1, 1, 0, 0, 0));
      drive(1'b0, 7'd0, 3'd0, 1'b0);
      tick();
      check("bp_no_dup", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
